// File: rtl/ltc2308_scan_sequencer_if.sv
// Purpose: bundles the scan control, result strobe and LTC2308 pin signals of the sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; result strobes are not flow-controlled and the consumer must take each one.
interface ltc2308_scan_sequencer_if;
  logic        start;
  logic        continuous;
  logic [7:0]  channel_mask;
  logic        unipolar;
  logic        CONVST;
  logic        SCK;
  logic        SDI;
  logic        SDO;
  logic        busy;
  logic        result_valid;
  logic [2:0]  result_channel;
  logic [11:0] result_data;
  logic        scan_done;

  // Sequencer side: owns the ADC pins and the result strobe.
  modport master (
    input  start, continuous, channel_mask, unipolar, SDO,
    output CONVST, SCK, SDI, busy, result_valid, result_channel, result_data, scan_done
  );

  // Front-end / ADC side.
  modport slave (
    output start, continuous, channel_mask, unipolar, SDO,
    input  CONVST, SCK, SDI, busy, result_valid, result_channel, result_data, scan_done
  );
endinterface

// File: rtl/ltc2308_scan_sequencer.sv
// Purpose: scans the enabled LTC2308 channels in ascending order, one SPI frame per channel plus a prime frame.
// Latency: CONVST rises 1 clock after a request; each frame is CONVST_CYCLES+CONV_CYCLES+24*SCK_HALF+1 clocks.
// Backpressure: none; each result is a single-cycle strobe that the front-end must capture.
module ltc2308_scan_sequencer #(
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int SCK_HALF      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  ltc2308_scan_sequencer_if.master      bus
);

  typedef enum logic [2:0] {IDLE, CONV_PULSE, CONV_WAIT, SHIFT, EMIT} state_t;

  localparam logic [15:0] PULSE_LAST = 16'(CONVST_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] HALF_LAST  = 16'(SCK_HALF - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  mask_q, mask_d;
  logic        uni_q, uni_d;
  logic [2:0]  cfg_ch_q, cfg_ch_d;         // channel whose config is sent this frame
  logic [2:0]  emit_ch_q, emit_ch_d;       // channel whose conversion is read this frame
  logic [3:0]  frames_left_q, frames_left_d;
  logic        prime_q, prime_d;
  logic [11:0] shreg_q, shreg_d;
  logic        convst_q, convst_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        busy_q, busy_d;
  logic        result_valid_q, result_valid_d;
  logic [2:0]  result_channel_q, result_channel_d;
  logic [11:0] result_data_q, result_data_d;
  logic        scan_done_q, scan_done_d;
  logic        launch;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Next enabled channel above cur, wrapping to the lowest one; the wrap is
  // what makes the final frame carry the first channel's config.
  function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    r = lowest_bit(m);
    for (int i = 7; i >= 0; i--) if (m[i] && (i > int'(cur))) r = 3'(i);
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r + {3'b000, m[i]};
    return r;
  endfunction

  // SDI level for serial bit b (0 = first on the wire): 6 config bits then zeros.
  function automatic logic cfg_bit(input logic [2:0] ch, input logic uni, input logic [3:0] b);
    logic [11:0] f;
    f = {1'b1, ch[0], ch[2], ch[1], uni, 1'b0, 6'b000000};
    return f[4'd11 - b];
  endfunction

  // Next-state and registered-output logic for the scan FSM.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bit_d            = bit_q;
    mask_d           = mask_q;
    uni_d            = uni_q;
    cfg_ch_d         = cfg_ch_q;
    emit_ch_d        = emit_ch_q;
    frames_left_d    = frames_left_q;
    prime_d          = prime_q;
    shreg_d          = shreg_q;
    convst_d         = convst_q;
    sck_d            = sck_q;
    sdi_d            = sdi_q;
    result_valid_d   = 1'b0;
    result_channel_d = result_channel_q;
    result_data_d    = result_data_q;
    scan_done_d      = 1'b0;
    launch           = 1'b0;

    case (state_q)
      IDLE: begin
        if ((bus.start || bus.continuous) && (bus.channel_mask != 8'h00)) launch = 1'b1;
      end
      CONV_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d  = CONV_WAIT;
          cnt_d    = '0;
          convst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CONV_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          sdi_d   = cfg_bit(cfg_ch_q, uni_q, 4'd0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            // Rising SCK: capture the ADC bit on the same clock.
            sck_d   = 1'b1;
            shreg_d = {shreg_q[10:0], bus.SDO};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 4'd11) begin
              state_d        = EMIT;
              sdi_d          = 1'b0;
              result_valid_d = !prime_q;
              scan_done_d    = !prime_q && (frames_left_q == 4'd0);
              if (!prime_q) begin
                result_channel_d = emit_ch_q;
                result_data_d    = shreg_q;
              end
            end else begin
              bit_d = bit_q + 4'd1;
              sdi_d = cfg_bit(cfg_ch_q, uni_q, bit_q + 4'd1);
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      EMIT: begin
        prime_d   = 1'b0;
        emit_ch_d = cfg_ch_q;
        cfg_ch_d  = next_bit(mask_q, cfg_ch_q);
        if (frames_left_q != 4'd0) begin
          frames_left_d = frames_left_q - 4'd1;
          state_d       = CONV_PULSE;
          cnt_d         = '0;
          convst_d      = 1'b1;
        end else if (bus.continuous && (bus.channel_mask != 8'h00)) begin
          launch = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Scan start: latch settings, prime frame first, N channels take N+1 frames.
    if (launch) begin
      state_d       = CONV_PULSE;
      cnt_d         = '0;
      convst_d      = 1'b1;
      mask_d        = bus.channel_mask;
      uni_d         = bus.unipolar;
      cfg_ch_d      = lowest_bit(bus.channel_mask);
      frames_left_d = popcount(bus.channel_mask);
      prime_d       = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      bit_q            <= '0;
      mask_q           <= '0;
      uni_q            <= 1'b0;
      cfg_ch_q         <= '0;
      emit_ch_q        <= '0;
      frames_left_q    <= '0;
      prime_q          <= 1'b0;
      shreg_q          <= '0;
      convst_q         <= 1'b0;
      sck_q            <= 1'b0;
      sdi_q            <= 1'b0;
      busy_q           <= 1'b0;
      result_valid_q   <= 1'b0;
      result_channel_q <= '0;
      result_data_q    <= '0;
      scan_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_q            <= bit_d;
      mask_q           <= mask_d;
      uni_q            <= uni_d;
      cfg_ch_q         <= cfg_ch_d;
      emit_ch_q        <= emit_ch_d;
      frames_left_q    <= frames_left_d;
      prime_q          <= prime_d;
      shreg_q          <= shreg_d;
      convst_q         <= convst_d;
      sck_q            <= sck_d;
      sdi_q            <= sdi_d;
      busy_q           <= busy_d;
      result_valid_q   <= result_valid_d;
      result_channel_q <= result_channel_d;
      result_data_q    <= result_data_d;
      scan_done_q      <= scan_done_d;
    end
  end

  assign bus.CONVST         = convst_q;
  assign bus.SCK            = sck_q;
  assign bus.SDI            = sdi_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_channel = result_channel_q;
  assign bus.result_data    = result_data_q;
  assign bus.scan_done      = scan_done_q;

endmodule

// File: tb/tb_ltc2308_scan_sequencer.sv
// Purpose: bench for the scan sequencer with a behavioural LTC2308 model and a scan-level reference.
// Latency: checks CONVST 1 clock after start and (N+1) frames of busy per scan.
// Backpressure: none; every strobe seen on the bus is recorded and compared.
module tb_ltc2308_scan_sequencer;
  localparam int F = 2 + 80 + 24 * 2 + 1;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] dat;
    logic        done;
  } stb_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ltc2308_scan_sequencer_if bus();

  ltc2308_scan_sequencer #(.CONVST_CYCLES(2), .CONV_CYCLES(80), .SCK_HALF(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ADC model and bus recorder state (written only by the monitor).
  logic [11:0] adc_val [8];
  logic [11:0] adc_word, garbage, sdi_sh;
  logic        conv_prev, sck_prev, sel_vld, sdo_r;
  logic [2:0]  sel_ch;
  int          sck_n = 0, n_convst = 0, busy_cyc = 0, n_done_only = 0;
  logic [11:0] sdi_words [$];
  stb_t        stbs [$];

  // Reference expectations (written only by the test tasks).
  logic [5:0]  exp_sdi [$];
  stb_t        exp_stb [$];

  assign bus.SDO = sdo_r;

  // LTC2308 model: a conversion started by CONVST uses the config of the previous frame;
  // data goes out MSB first, advancing on SCK falling edges.
  always @(negedge clock) begin
    conv_prev <= bus.CONVST;
    sck_prev  <= bus.SCK;
    garbage   <= 12'($urandom);
    if (reset) begin
      sck_n   <= 0;
      sel_vld <= 1'b0;
      sdo_r   <= 1'b0;
    end else begin
      if (bus.busy === 1'b1) busy_cyc <= busy_cyc + 1;
      if (bus.CONVST === 1'b1 && conv_prev === 1'b0) begin
        n_convst <= n_convst + 1;
        adc_word <= sel_vld ? adc_val[sel_ch] : garbage;
        sdo_r    <= sel_vld ? adc_val[sel_ch][11] : garbage[11];
      end
      if (bus.SCK === 1'b0 && sck_prev === 1'b1) begin
        adc_word <= {adc_word[10:0], 1'b0};
        sdo_r    <= adc_word[10];
      end
      if (bus.SCK === 1'b1 && sck_prev === 1'b0) begin
        sdi_sh <= {sdi_sh[10:0], bus.SDI};
        if (sck_n == 11) begin
          sdi_words.push_back({sdi_sh[10:0], bus.SDI});
          sel_ch  <= {sdi_sh[8], sdi_sh[7], sdi_sh[9]};
          sel_vld <= 1'b1;
          sck_n   <= 0;
        end else begin
          sck_n <= sck_n + 1;
        end
      end
    end
    if (bus.result_valid === 1'b1) stbs.push_back({bus.result_channel, bus.result_data, bus.scan_done});
    else if (bus.scan_done === 1'b1) n_done_only <= n_done_only + 1;
  end

  function automatic logic [5:0] exp_cfg(input logic [2:0] ch, input logic uni);
    return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
  endfunction

  // One scan at the wire level: config of each enabled channel ascending, then the first
  // again; strobes in ascending order carrying the ADC value, done on the last one.
  task automatic model_scan(input logic [7:0] m, input logic uni);
    int first, last;
    first = -1;
    last  = -1;
    for (int c = 0; c < 8; c++) if (m[c]) begin
      if (first < 0) first = c;
      last = c;
    end
    for (int c = 0; c < 8; c++) if (m[c]) begin
      exp_sdi.push_back(exp_cfg(3'(c), uni));
      exp_stb.push_back({3'(c), adc_val[c], (c == last)});
    end
    exp_sdi.push_back(exp_cfg(3'(first), uni));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic u);
    bus.channel_mask = m;
    bus.unipolar     = u;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 12 * F) begin
      tick();
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_timeout busy=%b want 0", nm, bus.busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      total++; if (bus.CONVST !== 1'b0) begin bad++; $display("FAIL reset_convst got=%b want 0", bus.CONVST); end
      total++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want 0", bus.SCK); end
      total++; if (bus.SDI !== 1'b0) begin bad++; $display("FAIL reset_sdi got=%b want 0", bus.SDI); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want 0", bus.busy); end
      total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want 0", bus.result_valid); end
      total++; if (bus.result_channel !== 3'd0) begin bad++; $display("FAIL reset_chan got=%0d want 0", bus.result_channel); end
      total++; if (bus.result_data !== 12'h000) begin bad++; $display("FAIL reset_data got=%h want 000", bus.result_data); end
      total++; if (bus.scan_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want 0", bus.scan_done); end
      reset = 1'b0;
      tick();
    end
  endtask

  task automatic test_single_scan();
    logic [7:0] m;
    logic       u;
    logic [5:0] lit [3];
    int b_conv, b_busy, b_sdi, b_stb, b_done, nlit;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
      nlit = 0;
      if (k == 0) begin
        m = 8'h05; u = 1'b1; adc_val[0] = 12'h123; adc_val[2] = 12'hABC;
        lit[0] = 6'b100010; lit[1] = 6'b100110; lit[2] = 6'b100010; nlit = 3;
      end else if (k == 1) begin
        m = 8'h80; u = 1'b0;
        lit[0] = 6'b111100; lit[1] = 6'b111100; lit[2] = 6'b000000; nlit = 2;
      end else begin
        m = 8'($urandom_range(1, 255)); u = 1'($urandom_range(0, 1));
      end
      exp_sdi.delete(); exp_stb.delete();
      model_scan(m, u);
      b_conv = n_convst; b_busy = busy_cyc; b_sdi = sdi_words.size(); b_stb = stbs.size(); b_done = n_done_only;
      pulse_start(m, u);
      total++; if (bus.CONVST !== 1'b1) begin bad++; $display("FAIL single_convst_latency case=%0d got=%b want 1", k, bus.CONVST); end
      wait_idle("single");
      total++; if (n_convst - b_conv !== exp_sdi.size()) begin bad++; $display("FAIL single_convst_count case=%0d got=%0d want=%0d", k, n_convst - b_conv, exp_sdi.size()); end
      total++; if (busy_cyc - b_busy !== exp_sdi.size() * F) begin bad++; $display("FAIL single_busy_len case=%0d got=%0d want=%0d", k, busy_cyc - b_busy, exp_sdi.size() * F); end
      if (k == 0) begin
        total++; if (busy_cyc - b_busy !== 393) begin bad++; $display("FAIL single_busy_393 got=%0d want=393", busy_cyc - b_busy); end
      end
      total++; if (n_done_only !== b_done) begin bad++; $display("FAIL single_done_alone case=%0d got=%0d want=%0d", k, n_done_only - b_done, 0); end
      total++; if (sdi_words.size() - b_sdi !== exp_sdi.size()) begin bad++; $display("FAIL single_sdi_count case=%0d got=%0d want=%0d", k, sdi_words.size() - b_sdi, exp_sdi.size()); end
      for (int i = 0; i < exp_sdi.size(); i++) begin
        logic [11:0] w;
        w = (b_sdi + i < sdi_words.size()) ? sdi_words[b_sdi + i] : 12'hxxx;
        total++; if (w !== {exp_sdi[i], 6'b000000}) begin bad++; $display("FAIL single_sdi case=%0d frame=%0d got=%b want=%b", k, i, w, {exp_sdi[i], 6'b000000}); end
        if (i < nlit) begin
          total++; if (w[11:6] !== lit[i]) begin bad++; $display("FAIL single_sdi_literal case=%0d frame=%0d got=%b want=%b", k, i, w[11:6], lit[i]); end
        end
      end
      total++; if (stbs.size() - b_stb !== exp_stb.size()) begin bad++; $display("FAIL single_stb_count case=%0d got=%0d want=%0d", k, stbs.size() - b_stb, exp_stb.size()); end
      for (int i = 0; i < exp_stb.size(); i++) begin
        stb_t s;
        s = (b_stb + i < stbs.size()) ? stbs[b_stb + i] : 'x;
        total++; if (s !== exp_stb[i]) begin bad++; $display("FAIL single_stb case=%0d idx=%0d got ch=%0d dat=%h done=%b want ch=%0d dat=%h done=%b", k, i, s.ch, s.dat, s.done, exp_stb[i].ch, exp_stb[i].dat, exp_stb[i].done); end
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_mask_zero();
    int b_conv, b_stb, seen;
    b_conv = n_convst; b_stb = stbs.size(); seen = 0;
    pulse_start(8'h00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) bus.continuous = 1'b1;
      if (bus.busy !== 1'b0 || bus.CONVST !== 1'b0) seen++;
      tick();
    end
    bus.continuous = 1'b0;
    tick();
    total++; if (seen !== 0) begin bad++; $display("FAIL mask0_busy cycles_active=%0d want 0", seen); end
    total++; if (n_convst - b_conv !== 0) begin bad++; $display("FAIL mask0_convst got=%0d want 0", n_convst - b_conv); end
    total++; if (stbs.size() - b_stb !== 0) begin bad++; $display("FAIL mask0_strobes got=%0d want 0", stbs.size() - b_stb); end
  endtask

  task automatic test_continuous();
    int b_conv, b_busy, b_sdi, b_stb, n;
    logic u;
    u = 1'($urandom_range(0, 1));
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
    exp_sdi.delete(); exp_stb.delete();
    model_scan(8'hFF, u);
    model_scan(8'hFF, u);
    b_conv = n_convst; b_busy = busy_cyc; b_sdi = sdi_words.size(); b_stb = stbs.size();
    bus.channel_mask = 8'hFF; bus.unipolar = u; bus.continuous = 1'b1;
    n = 0;
    while (stbs.size() - b_stb < 8 && n < 12 * F) begin tick(); n++; end
    total++; if (stbs.size() - b_stb < 8) begin bad++; $display("FAIL cont_first_scan strobes=%0d want 8", stbs.size() - b_stb); end
    repeat (300) tick();
    bus.continuous = 1'b0;
    wait_idle("cont");
    total++; if (n_convst - b_conv !== 18) begin bad++; $display("FAIL cont_convst got=%0d want 18", n_convst - b_conv); end
    total++; if (busy_cyc - b_busy !== 18 * F) begin bad++; $display("FAIL cont_busy_len got=%0d want=%0d", busy_cyc - b_busy, 18 * F); end
    total++; if (sdi_words.size() - b_sdi !== exp_sdi.size()) begin bad++; $display("FAIL cont_sdi_count got=%0d want=%0d", sdi_words.size() - b_sdi, exp_sdi.size()); end
    for (int i = 0; i < exp_sdi.size(); i++) begin
      logic [11:0] w;
      w = (b_sdi + i < sdi_words.size()) ? sdi_words[b_sdi + i] : 12'hxxx;
      total++; if (w !== {exp_sdi[i], 6'b000000}) begin bad++; $display("FAIL cont_sdi frame=%0d got=%b want=%b", i, w, {exp_sdi[i], 6'b000000}); end
    end
    total++; if (stbs.size() - b_stb !== 16) begin bad++; $display("FAIL cont_stb_count got=%0d want 16", stbs.size() - b_stb); end
    for (int i = 0; i < exp_stb.size(); i++) begin
      stb_t s;
      s = (b_stb + i < stbs.size()) ? stbs[b_stb + i] : 'x;
      total++; if (s !== exp_stb[i]) begin bad++; $display("FAIL cont_stb idx=%0d got ch=%0d dat=%h done=%b want ch=%0d dat=%h done=%b", i, s.ch, s.dat, s.done, exp_stb[i].ch, exp_stb[i].dat, exp_stb[i].done); end
    end
    repeat (5) tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cont_stays_idle busy=%b want 0", bus.busy); end
  endtask

  task automatic test_start_while_busy();
    int b_conv, b_stb;
    logic [7:0] m;
    logic u;
    m = 8'($urandom_range(1, 255)); u = 1'($urandom_range(0, 1));
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
    exp_sdi.delete(); exp_stb.delete();
    model_scan(m, u);
    b_conv = n_convst; b_stb = stbs.size();
    pulse_start(m, u);
    repeat (150) tick();
    pulse_start(m ^ 8'hA5, ~u);
    wait_idle("busy_start");
    total++; if (n_convst - b_conv !== exp_sdi.size()) begin bad++; $display("FAIL busy_start_convst got=%0d want=%0d", n_convst - b_conv, exp_sdi.size()); end
    total++; if (stbs.size() - b_stb !== exp_stb.size()) begin bad++; $display("FAIL busy_start_stb_count got=%0d want=%0d", stbs.size() - b_stb, exp_stb.size()); end
    for (int i = 0; i < exp_stb.size(); i++) begin
      stb_t s;
      s = (b_stb + i < stbs.size()) ? stbs[b_stb + i] : 'x;
      total++; if (s !== exp_stb[i]) begin bad++; $display("FAIL busy_start_stb idx=%0d got ch=%0d dat=%h done=%b want ch=%0d dat=%h done=%b", i, s.ch, s.dat, s.done, exp_stb[i].ch, exp_stb[i].dat, exp_stb[i].done); end
    end
    repeat (5) tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_shift();
    int b_conv, b_stb, n;
    b_conv = n_convst; b_stb = stbs.size();
    pulse_start(8'h03, 1'b1);
    n = 0;
    while (!(n_convst - b_conv >= 2 && bus.SCK === 1'b1) && n < 4 * F) begin tick(); n++; end
    total++; if (bus.SCK !== 1'b1) begin bad++; $display("FAIL rst_mid_reach_shift sck=%b want 1", bus.SCK); end
    reset = 1'b1;
    tick();
    total++; if (bus.CONVST !== 1'b0) begin bad++; $display("FAIL rst_mid_convst got=%b want 0", bus.CONVST); end
    total++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL rst_mid_sck got=%b want 0", bus.SCK); end
    total++; if (bus.SDI !== 1'b0) begin bad++; $display("FAIL rst_mid_sdi got=%b want 0", bus.SDI); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want 0", bus.busy); end
    reset = 1'b0;
    repeat (3) tick();
    total++; if (stbs.size() - b_stb !== 0) begin bad++; $display("FAIL rst_mid_no_strobe got=%0d want 0", stbs.size() - b_stb); end
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
    exp_sdi.delete(); exp_stb.delete();
    model_scan(8'h06, 1'b0);
    b_conv = n_convst; b_stb = stbs.size();
    pulse_start(8'h06, 1'b0);
    wait_idle("rst_mid_rescan");
    total++; if (n_convst - b_conv !== 3) begin bad++; $display("FAIL rst_mid_rescan_convst got=%0d want 3", n_convst - b_conv); end
    total++; if (stbs.size() - b_stb !== exp_stb.size()) begin bad++; $display("FAIL rst_mid_rescan_count got=%0d want=%0d", stbs.size() - b_stb, exp_stb.size()); end
    for (int i = 0; i < exp_stb.size(); i++) begin
      stb_t s;
      s = (b_stb + i < stbs.size()) ? stbs[b_stb + i] : 'x;
      total++; if (s !== exp_stb[i]) begin bad++; $display("FAIL rst_mid_rescan_stb idx=%0d got ch=%0d dat=%h done=%b want ch=%0d dat=%h done=%b", i, s.ch, s.dat, s.done, exp_stb[i].ch, exp_stb[i].dat, exp_stb[i].done); end
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.continuous   = 1'b0;
    bus.channel_mask = 8'h00;
    bus.unipolar     = 1'b0;
    reset            = 1'b1;
    test_reset();
    test_single_scan();
    test_mask_zero();
    test_continuous();
    test_start_while_busy();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
